signature_serializer: RTL and testbench
=======================================

Name: signature_serializer

Overview:
Parametrised successor of the fixed 256-bit signature shifter. It streams a compile-time constant message (default: the 32-character ASCII design banner) one bit per enabled cycle on q. It adds a start/busy/done handshake, selectable bit order, one-shot or looping mode, and a per-cycle stall. It sits beside the cipher datapath as the chip's identification/test output.

Parameters:
MSG_BITS, 256, message length in bits; legal range 1..4096.
MSG, signature_pkg::DEFAULT_SIG (MSG_BITS wide), constant message contents.
LSB_FIRST, 0, 0 = send MSG[MSG_BITS-1] first; 1 = send MSG[0] first.
IDX_W, $clog2(MSG_BITS) with a minimum of 1, index counter width; derived, not overridden.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin transmission; sampled in IDLE only
loop_en  in  1  sampled at each wrap point: 1 = restart the message, 0 = stop
enable  in  1  advance strobe; 0 stalls in place
q  out  1  current message bit; 0 when not SEND/PAR
q_valid  out  1  q carries a bit consumed this cycle (state is SEND or PAR, and enable=1)
busy  out  1  state is not IDLE
done  out  1  registered one-cycle pulse after the final bit of each pass
bit_idx  out  IDX_W  current message index

Behaviour:
- Reset (async assert, sync deassert by upstream):
  - state=IDLE; bit_idx=FIRST (MSG_BITS-1, or 0 if LSB_FIRST); done=0.
  - Hence q=0, q_valid=0, busy=0.
  - Reset mid-transfer aborts immediately; no done is issued.
- States: IDLE, SEND, PAR (PAR exists only with the optional feature).
- IDLE:
  - start=1 moves to SEND next cycle with bit_idx=FIRST.
  - First bit appears on q the cycle after start, i.e. latency 1.
- SEND:
  - q = MSG[bit_idx], combinational from the registered index.
  - enable=1: the bit is consumed and bit_idx steps toward LAST (decrement for MSB-first, increment for LSB-first).
  - enable=0: bit_idx, q and state hold; q_valid=0.
- Wrap point (enable=1 at bit_idx==LAST, or at the PAR cycle):
  - done=1 on the next cycle.
  - If loop_en=1: bit_idx=FIRST and state stays SEND, so there is no gap bit.
  - If loop_en=0: state=IDLE and bit_idx=FIRST.
- start while busy is ignored. start on the same edge the block returns to IDLE is also ignored; a new start is accepted from IDLE on the following cycle.
- MSG_BITS=1: FIRST==LAST, so each enabled SEND cycle is a wrap point.
- No arithmetic overflow: the index never leaves 0..MSG_BITS-1 (explicit reload, no modulo wrap).

Optional Feature:
SIGNATURE_PARITY_EN.
- Defined:
  - After the LAST bit is consumed, state=PAR for one enabled cycle; q = ^MSG (even parity, elaboration-time constant), q_valid=enable.
  - The wrap point moves to PAR, and the loop_en decision is taken there.
  - A stall in PAR holds.
- Undefined: PAR state and parity logic are absent; passes are exactly MSG_BITS enabled cycles.

Decomposition:
- signature_pkg:
  - state enum (IDLE/SEND/PAR)
  - DEFAULT_SIG 256-bit constant ("Luke Vassallo Tiny Tapeout 2023." ASCII)
  - function sig_first(MSG_BITS, LSB_FIRST)
  - function sig_last(MSG_BITS, LSB_FIRST)
- Sub-module signature_bit_counter:
  - Up/down loadable index counter.
  - Ports: load, step, dir, load value, at_last flag.
- FSM and output muxing stay in the top module.

Test Plan:
- MSG_BITS=8, MSG=8'hA5, LSB_FIRST=0, start pulse, enable=1, loop_en=0 -> q=1,0,1,0,0,1,0,1 on cycles 1..8; done=1 on cycle 9; busy=0 from cycle 9.
- Same configuration with LSB_FIRST=1 -> q=1,0,1,0,0,1,0,1 (8'hA5 is a palindrome); repeat with MSG=8'h0F -> MSB-first 0,0,0,0,1,1,1,1 and LSB-first 1,1,1,1,0,0,0,0.
- MSG=8'h0F, enable low on cycles 3-5 -> q holds at bit_idx 5 with q_valid=0; sequence resumes unchanged; done delayed by 3 cycles.
- loop_en=1 for 20 cycles, MSG_BITS=8 -> continuous repeating stream; done pulses on cycles 9 and 17; no idle bit between passes.
- reset_n low at bit 4 -> same-cycle q=0, busy=0, bit_idx=7; no done pulse; a later start replays from bit 7.
- SIGNATURE_PARITY_EN, MSG=8'h07 -> 8 data bits then q=1 (parity), q_valid=1; done on cycle 10.

Source files
------------

// File: rtl/signature_serializer_pkg.sv
// -----------------------------------------------------------------------------
// signature_pkg
// Shared types and helpers for the signature serializer:
//   - sig_state_t   : serializer FSM states (IDLE / SEND / PAR)
//   - DEFAULT_SIG   : 256-bit ASCII design banner, first character in the MSBs
//   - sig_idx_w     : index counter width for a message length (minimum 1)
//   - sig_first     : index of the first bit sent for a given bit order
//   - sig_last      : index of the last bit sent for a given bit order
// -----------------------------------------------------------------------------
package signature_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_PAR  = 2'd2
  } sig_state_t;

  // 32 characters * 8 bits = 256 bits; the string literal packs 'L' into [255:248].
  localparam logic [255:0] DEFAULT_SIG = "Luke Vassallo Tiny Tapeout 2023.";

  function automatic int sig_idx_w(input int msg_bits);
    return (msg_bits > 1) ? $clog2(msg_bits) : 1;
  endfunction

  function automatic int sig_first(input int msg_bits, input bit lsb_first);
    return lsb_first ? 0 : msg_bits - 1;
  endfunction

  function automatic int sig_last(input int msg_bits, input bit lsb_first);
    return lsb_first ? msg_bits - 1 : 0;
  endfunction

endpackage

// File: rtl/signature_serializer_if.sv
// -----------------------------------------------------------------------------
// signature_serializer_if
// Handshake/stream bundle between a controller and the signature serializer.
//   start    : controller -> serializer, begin a transmission (IDLE only)
//   loop_en  : controller -> serializer, restart (1) or stop (0) at a wrap point
//   enable   : controller -> serializer, advance strobe, 0 stalls in place
//   q        : serializer -> controller, current message bit
//   q_valid  : serializer -> controller, q is consumed this cycle
//   busy     : serializer -> controller, transmission in progress
//   done     : serializer -> controller, one-cycle pulse after each pass
//   bit_idx  : serializer -> controller, current message index
// Modports: master (controller side), slave (serializer side).
// -----------------------------------------------------------------------------
interface signature_serializer_if
  import signature_pkg::*;
#(
  parameter int MSG_BITS = 256
) ();

  localparam int IDX_W = sig_idx_w(MSG_BITS);

  logic             start;
  logic             loop_en;
  logic             enable;
  logic             q;
  logic             q_valid;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] bit_idx;

  modport master (
    output start, loop_en, enable,
    input  q, q_valid, busy, done, bit_idx
  );

  modport slave (
    input  start, loop_en, enable,
    output q, q_valid, busy, done, bit_idx
  );

endinterface

// File: rtl/signature_serializer_bit_counter.sv
// -----------------------------------------------------------------------------
// signature_bit_counter
// Loadable up/down message index counter. Load has priority over step; the
// counter never wraps on its own, the owner reloads it at the end of a pass.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset, index returns to RST_VAL
//   i_load     : load i_load_val
//   i_step     : advance one position in direction i_dir
//   i_dir      : 1 = count up, 0 = count down
//   i_load_val : value loaded by i_load
//   o_idx      : current index
//   o_at_last  : index equals LAST_VAL
// -----------------------------------------------------------------------------
module signature_bit_counter #(
  parameter int               IDX_W    = 8,
  parameter logic [IDX_W-1:0] RST_VAL  = '0,
  parameter logic [IDX_W-1:0] LAST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_dir,
  input  logic [IDX_W-1:0] i_load_val,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_at_last
);

  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= RST_VAL;
    end else if (i_load) begin
      r_idx <= i_load_val;
    end else if (i_step) begin
      r_idx <= i_dir ? (r_idx + IDX_W'(1)) : (r_idx - IDX_W'(1));
    end
  end

  assign o_idx     = r_idx;
  assign o_at_last = (r_idx == LAST_VAL);

endmodule

// File: rtl/signature_serializer.sv
// -----------------------------------------------------------------------------
// signature_serializer
// Streams the constant message MSG one bit per enabled cycle, with a
// start/busy/done handshake, selectable bit order, one-shot or looping mode
// and a per-cycle stall.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (aborts a pass, no done)
//   bus     : signature_serializer_if.slave (start, loop_en, enable in;
//             q, q_valid, busy, done, bit_idx out)
// Parameters: MSG_BITS (1..4096), MSG, LSB_FIRST.
// Build option: define SIGNATURE_PARITY_EN to append one even-parity bit
// (PAR state) after the last message bit of every pass; the wrap point and
// the loop_en decision then move to that PAR cycle.
// -----------------------------------------------------------------------------
module signature_serializer
  import signature_pkg::*;
#(
  parameter int                  MSG_BITS  = 256,
  parameter logic [MSG_BITS-1:0] MSG       = MSG_BITS'(DEFAULT_SIG),
  parameter bit                  LSB_FIRST = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  signature_serializer_if.slave  bus
);

  localparam int               IDX_W     = sig_idx_w(MSG_BITS);
  // Message padded to the full index range so every index value selects a bit.
  localparam int               PAD_W     = 1 << IDX_W;
  localparam logic [PAD_W-1:0] MSG_PAD   = PAD_W'(MSG);
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(sig_first(MSG_BITS, LSB_FIRST));
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(sig_last(MSG_BITS, LSB_FIRST));
`ifdef SIGNATURE_PARITY_EN
  localparam logic             MSG_PAR   = ^MSG;
`endif

  sig_state_t       r_state;
  logic             r_done;
  logic [IDX_W-1:0] w_idx;
  logic             w_at_last;
  logic             w_send_en;
  logic             w_wrap;
  logic             w_step;
  logic             w_q;

  assign w_send_en = (r_state == ST_SEND) && bus.enable;
  assign w_step    = w_send_en && !w_at_last;

`ifdef SIGNATURE_PARITY_EN
  // The last data bit hands over to PAR with the index parked at LAST;
  // the pass ends on the enabled PAR cycle.
  assign w_wrap = (r_state == ST_PAR) && bus.enable;
`else
  assign w_wrap = w_send_en && w_at_last;
`endif

  signature_bit_counter #(
    .IDX_W   (IDX_W),
    .RST_VAL (FIRST_IDX),
    .LAST_VAL(LAST_IDX)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_load    (w_wrap),
    .i_step    (w_step),
    .i_dir     (LSB_FIRST),
    .i_load_val(FIRST_IDX),
    .o_idx     (w_idx),
    .o_at_last (w_at_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_wrap;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (bus.enable && w_at_last) begin
`ifdef SIGNATURE_PARITY_EN
            r_state <= ST_PAR;
`else
            r_state <= bus.loop_en ? ST_SEND : ST_IDLE;
`endif
          end
        end
`ifdef SIGNATURE_PARITY_EN
        ST_PAR: begin
          if (bus.enable) r_state <= bus.loop_en ? ST_SEND : ST_IDLE;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_q = 1'b0;
    case (r_state)
      ST_SEND: w_q = MSG_PAD[w_idx];
`ifdef SIGNATURE_PARITY_EN
      ST_PAR:  w_q = MSG_PAR;
`endif
      default: w_q = 1'b0;
    endcase
  end

  assign bus.q       = w_q;
  assign bus.q_valid = (r_state != ST_IDLE) && bus.enable;
  assign bus.busy    = (r_state != ST_IDLE);
  assign bus.done    = r_done;
  assign bus.bit_idx = w_idx;

endmodule

// File: tb/tb_signature_serializer.sv
// -----------------------------------------------------------------------------
// tb_signature_serializer
// Four serializer instances (8-bit 0x0F MSB-first, 8-bit 0x0F LSB-first,
// default 256-bit banner MSB-first, 1-bit message) share one stimulus stream.
// A pass-position model predicts every output each cycle; directed sections
// pin the model with hand-computed sequences. Honours SIGNATURE_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_signature_serializer;

`ifdef SIGNATURE_PARITY_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif

  localparam logic [255:0] SIG = "Luke Vassallo Tiny Tapeout 2023.";

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic loop_en = 1'b0;
  logic enable = 1'b0;
  bit   chk_on = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  signature_serializer_if #(.MSG_BITS(8))   if0 ();
  signature_serializer_if #(.MSG_BITS(8))   if1 ();
  signature_serializer_if #(.MSG_BITS(256)) if2 ();
  signature_serializer_if #(.MSG_BITS(1))   if3 ();

  assign if0.start = start;  assign if0.loop_en = loop_en;  assign if0.enable = enable;
  assign if1.start = start;  assign if1.loop_en = loop_en;  assign if1.enable = enable;
  assign if2.start = start;  assign if2.loop_en = loop_en;  assign if2.enable = enable;
  assign if3.start = start;  assign if3.loop_en = loop_en;  assign if3.enable = enable;

  signature_serializer #(.MSG_BITS(8), .MSG(8'h0F), .LSB_FIRST(1'b0))
    u0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
  signature_serializer #(.MSG_BITS(8), .MSG(8'h0F), .LSB_FIRST(1'b1))
    u1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
  signature_serializer #(.MSG_BITS(256), .MSG(SIG), .LSB_FIRST(1'b0))
    u2 (.clk(clk), .reset_n(reset_n), .bus(if2.slave));
  signature_serializer #(.MSG_BITS(1), .MSG(1'b1), .LSB_FIRST(1'b0))
    u3 (.clk(clk), .reset_n(reset_n), .bus(if3.slave));

  // ---------------- reference model: position within the current pass -------
  int           nb   [4] = '{8, 8, 256, 1};
  bit           lsbf [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [255:0] mv   [4] = '{256'h0F, 256'h0F, SIG, 256'h1};

  bit m_act  [4];
  int m_pos  [4];
  bit m_done [4];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) begin
        m_act[k] = 1'b0; m_pos[k] = 0; m_done[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        m_done[k] = 1'b0;
        if (!m_act[k]) begin
          if (start) begin m_act[k] = 1'b1; m_pos[k] = 0; end
        end else if (enable) begin
          if (m_pos[k] == nb[k] + PX - 1) begin
            m_done[k] = 1'b1; m_pos[k] = 0; m_act[k] = loop_en;
          end else begin
            m_pos[k] = m_pos[k] + 1;
          end
        end
      end
    end
  end

  function automatic int msg_index(int k, int p);
    return lsbf[k] ? p : nb[k] - 1 - p;
  endfunction

  function automatic logic exp_q(int k);
    if (!m_act[k])          return 1'b0;
    if (m_pos[k] < nb[k])   return mv[k][msg_index(k, m_pos[k])];
    return ^mv[k];
  endfunction

  function automatic int exp_idx(int k);
    if (m_act[k] && m_pos[k] < nb[k]) return msg_index(k, m_pos[k]);
    if (m_act[k])                     return msg_index(k, nb[k] - 1);
    return msg_index(k, 0);
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s u%0d at %0t: got %0d expected %0d", nm, k, $time, a, e);
    end
  endtask

  task automatic cmp_inst(input int k, input logic q, input logic qv, input logic bsy,
                          input logic dn, input logic [31:0] idx);
    chk("q",       k, {31'd0, q},   {31'd0, exp_q(k)});
    chk("q_valid", k, {31'd0, qv},  {31'd0, m_act[k] && enable});
    chk("busy",    k, {31'd0, bsy}, {31'd0, m_act[k]});
    chk("done",    k, {31'd0, dn},  {31'd0, m_done[k]});
    chk("bit_idx", k, idx,          exp_idx(k));
  endtask

  always @(negedge clk) begin
    if (reset_n && chk_on) begin
      cmp_inst(0, if0.q, if0.q_valid, if0.busy, if0.done, 32'(if0.bit_idx));
      cmp_inst(1, if1.q, if1.q_valid, if1.busy, if1.done, 32'(if1.bit_idx));
      cmp_inst(2, if2.q, if2.q_valid, if2.busy, if2.done, 32'(if2.bit_idx));
      cmp_inst(3, if3.q, if3.q_valid, if3.busy, if3.done, 32'(if3.bit_idx));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [7:0] s0, s1, s2;
    int first_done, dcnt, d1, d2, bcnt, b;

    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_idx",  0, 32'(if0.bit_idx), 7);
    chk("rst_idx",  1, 32'(if1.bit_idx), 0);
    chk("rst_busy", 0, {31'd0, if0.busy}, 0);
    chk("rst_q",    0, {31'd0, if0.q}, 0);

    // single pass, enable held high
    tick(); start = 1'b1; enable = 1'b1; loop_en = 1'b0;
    s0 = '0; s1 = '0; s2 = '0; first_done = 0;
    for (int c = 1; c <= 12; c++) begin
      tick(); start = 1'b0;
      @(negedge clk);
      if (c <= 8) begin
        s0 = {s0[6:0], if0.q}; s1 = {s1[6:0], if1.q}; s2 = {s2[6:0], if2.q};
      end
      if (c == 9 && PX == 1) begin
        chk("parity_q",  0, {31'd0, if0.q}, 0);
        chk("parity_qv", 0, {31'd0, if0.q_valid}, 1);
      end
      if (c == 9 + PX) chk("busy_after", 0, {31'd0, if0.busy}, 0);
      if (if0.done && first_done == 0) first_done = c;
    end
    chk("seq_msb",    0, 32'(s0), 32'h0F);
    chk("seq_lsb",    1, 32'(s1), 32'hF0);
    chk("seq_banner", 2, 32'(s2), 32'h4C);
    chk("done_cycle", 0, first_done, 9 + PX);

    // stall on cycles 3..5
    tick(); start = 1'b1; enable = 1'b1;
    first_done = 0;
    for (int c = 1; c <= 16; c++) begin
      tick(); start = 1'b0; enable = !(c >= 3 && c <= 5);
      @(negedge clk);
      if (c == 4) begin
        chk("stall_idx", 0, 32'(if0.bit_idx), 5);
        chk("stall_qv",  0, {31'd0, if0.q_valid}, 0);
        chk("stall_q",   0, {31'd0, if0.q}, 0);
      end
      if (if0.done && first_done == 0) first_done = c;
    end
    chk("stall_done", 0, first_done, 12 + PX);

    // looping for 20 cycles
    tick(); start = 1'b1; enable = 1'b1; loop_en = 1'b1;
    dcnt = 0; d1 = 0; d2 = 0; bcnt = 0;
    for (int c = 1; c <= 20; c++) begin
      tick(); start = 1'b0;
      @(negedge clk);
      if (if0.q_valid) bcnt++;
      if (if0.done) begin
        dcnt++;
        if (d1 == 0) d1 = c; else if (d2 == 0) d2 = c;
      end
    end
    chk("loop_done1", 0, d1, 9 + PX);
    chk("loop_done2", 0, d2, 17 + 2 * PX);
    chk("loop_dcnt",  0, dcnt, 2);
    chk("loop_nogap", 0, bcnt, 20);
    b = 0;
    do begin
      tick(); loop_en = 1'b0;
      @(negedge clk);
      b++;
    end while (if0.busy && b < 60);
    chk("idle_wait", 0, {31'd0, if0.busy}, 0);

    // reset in the middle of a pass
    tick(); start = 1'b1; enable = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick(); start = 1'b0;
      @(negedge clk);
    end
    chk("pre_rst_idx", 0, 32'(if0.bit_idx), 4);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_idx",  0, 32'(if0.bit_idx), 7);
    chk("mid_rst_busy", 0, {31'd0, if0.busy}, 0);
    chk("mid_rst_q",    0, {31'd0, if0.q}, 0);
    chk("mid_rst_done", 0, {31'd0, if0.done}, 0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 0, {31'd0, if0.done}, 0);
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    @(negedge clk);
    chk("replay_idx",  0, 32'(if0.bit_idx), 7);
    chk("replay_busy", 0, {31'd0, if0.busy}, 1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick();
      start   = ($urandom_range(0, 3) == 0);
      enable  = ($urandom_range(0, 3) != 0);
      loop_en = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 599) == 0) begin
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
    end
    @(negedge clk);
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
